// File: rtl/threebit_add_arbiter.sv
// -----------------------------------------------------------------------------
// threebit_add_arbiter
//   Round-robin controller that shares one external WIDTH-bit adder among NREQ
//   requesters. The winning requester's operands are registered onto the
//   adder, held for SETTLE cycles, and then the adder's sum/carry are captured
//   and returned together with a one-cycle one-hot done pulse.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   WIDTH    operand width, matches the shared adder
//   SETTLE   cycles the operands are held on the adder before capture (>=1)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]        per-requester request level
//   a_in      in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in      in   [NREQ*WIDTH]  operand B, same packing
//   grant     out  [NREQ]        one-hot grant, zero when idle
//   done      out  [NREQ]        one-hot one-cycle completion pulse
//   sum_out   out  [WIDTH]       sum of the last completed operation
//   cout_out  out  1             carry of the last completed operation
//   busy      out  1             high whenever the controller is not idle
//   add_a     out  [WIDTH]       operand A driven to the shared adder
//   add_b     out  [WIDTH]       operand B driven to the shared adder
//   add_s     in   [WIDTH]       sum from the shared adder
//   add_cout  in   1             carry from the shared adder
// -----------------------------------------------------------------------------
module threebit_add_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 3,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  a_in,
    input  logic [NREQ*WIDTH-1:0]  b_in,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [WIDTH-1:0]       sum_out,
    output logic                   cout_out,
    output logic                   busy,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_cout
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [IDX_W-1:0]   w_win;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_start;
    logic               w_capture;
    logic               w_finish;

    // First set request bit scanning upward from the pointer, wrapping.
    function automatic logic [IDX_W-1:0] f_pick(input logic [NREQ-1:0]  i_req,
                                                 input logic [IDX_W-1:0] i_ptr);
        logic [IDX_W-1:0] v_pick;
        logic             v_found;
        int               v_idx;
        v_pick  = i_ptr;
        v_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(i_ptr) + k) % NREQ;
            if (!v_found && i_req[v_idx]) begin
                v_pick  = IDX_W'(v_idx);
                v_found = 1'b1;
            end
        end
        return v_pick;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control strobes derived from state
    always_comb begin
        w_win     = f_pick(req, r_ptr);
        w_start   = (r_state == S_IDLE) && (|req);
        w_capture = (r_state == S_WAIT) && (r_cnt == '0);
        w_finish  = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    // Datapath and output registers. The operands are latched only at grant,
    // so later changes on a_in/b_in or a dropped req cannot disturb the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_win    <= '0;
            r_cnt    <= '0;
            grant    <= '0;
            done     <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
        end else begin
            if (w_start) begin
                add_a <= a_in[int'(w_win)*WIDTH +: WIDTH];
                add_b <= b_in[int'(w_win)*WIDTH +: WIDTH];
                grant <= ONE_HOT0 << w_win;
                r_win <= w_win;
                r_cnt <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                sum_out  <= add_s;
                cout_out <= add_cout;
                done     <= ONE_HOT0 << r_win;
                r_ptr    <= (r_win == LAST_IDX) ? '0 : r_win + IDX_W'(1);
            end

            if (w_finish) begin
                grant <= '0;
                done  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_threebit_add_arbiter.sv
module tb_threebit_add_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 3;
    localparam int SETTLE = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  a_in;
    logic [NREQ*WIDTH-1:0]  b_in;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic [WIDTH-1:0]       sum_out;
    logic                   cout_out;
    logic                   busy;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_s;
    logic                   add_cout;
    logic [WIDTH:0]         w_full;

    // The bench plays the role of the shared external adder.
    assign w_full   = {1'b0, add_a} + {1'b0, add_b};
    assign add_s    = w_full[WIDTH-1:0];
    assign add_cout = w_full[WIDTH];

    threebit_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .grant    (grant),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_done"},  32'(done),  32'h0);
        chk({tag, "_busy"},  32'(busy),  32'h0);
        chk({tag, "_sum"},   32'(sum_out), 32'h0);
        chk({tag, "_cout"},  32'(cout_out), 32'h0);
        chk({tag, "_adda"},  32'(add_a), 32'h0);
        chk({tag, "_addb"},  32'(add_b), 32'h0);
    endtask

    // One complete transaction starting from IDLE; req is dropped right after
    // the grant edge so the next call starts cleanly.
    task automatic run_op(input string tag, input logic [3:0] r, input logic [11:0] a,
                          input logic [11:0] b, input int w, input logic [2:0] s,
                          input logic c);
        logic [11:0] va;
        logic [11:0] vb;
        va   = a;
        vb   = b;
        req  = r;
        a_in = a;
        b_in = b;
        tick();
        chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << w));
        chk({tag, "_busy"},  32'(busy), 32'h1);
        chk({tag, "_adda"},  32'(add_a), 32'(va[w*3 +: 3]));
        chk({tag, "_addb"},  32'(add_b), 32'(vb[w*3 +: 3]));
        req = '0;
        repeat (SETTLE - 1) begin
            tick();
            chk({tag, "_nodone"}, 32'(done), 32'h0);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'(4'b0001 << w));
        chk({tag, "_sum"},  32'(sum_out), 32'(s));
        chk({tag, "_cout"}, 32'(cout_out), 32'(c));
        chk({tag, "_grant_held"}, 32'(grant), 32'(4'b0001 << w));
        tick();
        chk({tag, "_done_clr"},  32'(done), 32'h0);
        chk({tag, "_grant_clr"}, 32'(grant), 32'h0);
        chk({tag, "_busy_clr"},  32'(busy), 32'h0);
        chk({tag, "_sum_hold"},  32'(sum_out), 32'(s));
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [11:0] a;
        logic [11:0] b;
        int          w;
        logic [2:0]  s;
        logic        c;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // slices are {req3, req2, req1, req0}; expected winners follow the
        // rotating pointer from the preceding vector.
        vecs[0] = '{4'b0001, {3'd7,3'd7,3'd7,3'd3}, {3'd6,3'd6,3'd6,3'd2}, 0, 3'd5, 1'b0};
        vecs[1] = '{4'b0100, {3'd1,3'd7,3'd1,3'd1}, {3'd1,3'd7,3'd1,3'd1}, 2, 3'd6, 1'b1};
        vecs[2] = '{4'b0010, {3'd0,3'd0,3'd4,3'd0}, {3'd0,3'd0,3'd4,3'd0}, 1, 3'd0, 1'b1};
        vecs[3] = '{4'b1001, {3'd5,3'd0,3'd0,3'd0}, {3'd1,3'd0,3'd0,3'd0}, 3, 3'd6, 1'b0};
        vecs[4] = '{4'b1001, {3'd6,3'd6,3'd6,3'd2}, {3'd6,3'd6,3'd6,3'd3}, 0, 3'd5, 1'b0};
        vecs[5] = '{4'b1111, {3'd1,3'd1,3'd7,3'd1}, {3'd1,3'd1,3'd0,3'd1}, 1, 3'd7, 1'b0};
        vecs[6] = '{4'b0001, {3'd0,3'd0,3'd0,3'd1}, {3'd0,3'd0,3'd0,3'd7}, 0, 3'd0, 1'b1};
        vecs[7] = '{4'b1100, {3'd3,3'd6,3'd3,3'd3}, {3'd3,3'd5,3'd3,3'd3}, 2, 3'd3, 1'b1};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].b,
                   vecs[i].w, vecs[i].s, vecs[i].c);
        end

        // Operands changed and req dropped during WAIT must not matter.
        do_reset();
        req  = 4'b0010;
        a_in = {3'd0, 3'd0, 3'd2, 3'd0};
        b_in = {3'd0, 3'd0, 3'd1, 3'd0};
        tick();
        chk("chg_grant", 32'(grant), 32'h2);
        a_in = '1;
        b_in = '1;
        req  = '0;
        tick();
        chk("chg_adda", 32'(add_a), 32'h2);
        chk("chg_busy", 32'(busy), 32'h1);
        tick();
        chk("chg_done", 32'(done), 32'h2);
        chk("chg_sum",  32'(sum_out), 32'h3);
        chk("chg_cout", 32'(cout_out), 32'h0);
        tick();
        chk("chg_idle", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of WAIT.
        req  = 4'b0001;
        a_in = {3'd0, 3'd0, 3'd0, 3'd7};
        b_in = {3'd0, 3'd0, 3'd0, 3'd7};
        tick();
        chk("rstw_grant", 32'(grant), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstw_async");
        tick();
        tick();
        chk("rstw_nodone", 32'(done), 32'h0);
        chk("rstw_busy",   32'(busy), 32'h0);
        rst_n = 1'b1;
        run_op("rstw_after", 4'b0100, {3'd7, 3'd3, 3'd7, 3'd7},
               {3'd7, 3'd4, 3'd7, 3'd7}, 2, 3'd7, 1'b0);

        // Continuous requests from everyone: strict rotation 0,1,2,3,0.
        do_reset();
        req  = 4'b1111;
        a_in = {3'd1, 3'd1, 3'd1, 3'd1};
        b_in = {3'd1, 3'd1, 3'd1, 3'd1};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            repeat (SETTLE) tick();
            chk($sformatf("rr%0d_done", k), 32'(done), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d_sum", k),  32'(sum_out), 32'h2);
            tick();
            chk($sformatf("rr%0d_gap", k),  32'(grant), 32'h0);
        end
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
